decr_timer: RTL and testbench
=============================

Name: decr_timer

Overview:
- Loadable down-counter and timer built on a fast decrementor: group-borrow lookahead over 8-bit groups, the complement of the team's fast incrementors.
- Software or a controller loads a start value through a valid/ready handshake. The block counts down on enable cycles and raises a one-cycle expire pulse when the count reaches zero.
- Used as the timeout and delay companion to the Incr9/Incr16 counting blocks.

Parameters:
- W, 16, counter width in bits; legal range 2..32.
- GRP, 8, borrow-lookahead group size in bits; W need not be a multiple of GRP (the top group is partial).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- load_vld  input  1  load request valid.
- load_rdy  output  1  block can accept a load.
- load_val  input  W  start value, captured when load_vld && load_rdy.
- en  input  1  count enable; one decrement per clk cycle while high in RUN.
- abort  input  1  stop the run and return to IDLE.
- cnt  output  W  current count (registered).
- busy  output  1  high in RUN.
- expire  output  1  one-cycle pulse, coincident with the first cycle cnt==0 after a run.

Behaviour:
- Reset (rst_n low at an edge): state=IDLE, cnt=0, busy=0, expire=0, load_rdy=1, reload register=0. Reset overrides every other input, including mid-run.
- States: IDLE, RUN, DONE (2-bit encoding). busy = (state==RUN). load_rdy = (state!=RUN).
- IDLE or DONE, load accepted:
  - load_val!=0: next cnt=load_val, state=RUN.
  - load_val==0: next cnt=0, state=DONE, expire=1 on the next cycle (the zero-length timer still expires exactly once).
- RUN, en=1: cnt_next = cnt-1 via the fast decrementor.
  - Group g borrows when all lower bits are 0.
  - Borrow into a group = AND of the lower groups' all-zero flags.
  - Bits within a group: bit i flips when bits [i-1:0] of cnt are all 0.
  - No wrap: RUN is never entered with cnt==0.
- RUN, en=0: cnt holds.
- RUN, cnt==1 and en=1: next cnt=0, state=DONE, expire=1 for exactly that next cycle.
- DONE: cnt holds 0, expire=0 after its pulse, load_rdy=1. A load in the same cycle as the expire pulse is accepted.
- abort=1 in RUN: next state=IDLE, cnt holds its current value, no expire. Abort has priority over en.
- abort=1 in IDLE or DONE: no effect. A load in the same cycle still proceeds; abort is ignored outside RUN.
- load_vld while in RUN: ignored (load_rdy=0); load_val is not captured.
- Latency:
  - Load to first decrement: the first en cycle after the load edge.
  - Load of N with en held high: expire is seen N cycles after the load edge.
- Unit is combinational decrement plus a single register stage; no multicycle paths.

Optional Feature:
DECR_TIMER_RELOAD_EN
- Defined:
  - Every accepted load_val is also stored in a reload register.
  - On the RUN expiry transition (cnt==1, en=1): cnt_next = reload value, state stays RUN, busy stays 1, and expire still pulses for one cycle while cnt shows the reload value.
  - Result is a periodic tick every N enabled cycles. Only abort or reset exits RUN.
  - A load of 0 behaves as without the macro (DONE plus a single expire).
- Undefined: no reload register; expiry always goes to DONE as described in Behaviour.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> cnt=0, busy=0, expire=0, load_rdy=1.
- Basic run: load 5, en held at 1 -> cnt 5,4,3,2,1,0 on successive cycles; expire=1 only on the cycle cnt=0, then state DONE, load_rdy=1.
- Lookahead borrow, W=16:
  - load 16'h0100, one en cycle -> cnt=16'h00FF.
  - load 16'h8000 -> 16'h7FFF.
  - load 16'h0001 -> 0 with expire.
- Gated en and abort: load 10, en toggles 1,0,1,0 -> cnt 9,9,8,8. Then abort=1 with en=1 -> IDLE, cnt=8, no expire; load_vld during RUN is not taken.
- Zero load plus load-on-expire: load 0 -> DONE and expire next cycle. Load 3 in the same cycle as an expire pulse -> accepted, cnt=3, busy=1.
- Reload (DECR_TIMER_RELOAD_EN): load 3, en=1 -> expire every 3rd cycle, cnt cycling 3,2,1,3,2,1 while busy stays 1. Reset mid-run -> cnt=0, IDLE.

Source files
------------

// File: rtl/decr_timer_if.sv
// decr_timer_if: load handshake, run control and status bundle for decr_timer.
// Latency: none (wires only).
// Backpressure: load_rdy low while the timer is running; load_vld is ignored then.
//
// Signals:
//   load_vld / load_rdy / load_val : start-value handshake (master -> timer)
//   en, abort                      : count enable and run abort (master -> timer)
//   cnt, busy, expire              : registered status (timer -> master)
// Modports: master (controller side), slave (timer side).
interface decr_timer_if #(
    parameter int W = 16
) ();
    logic         load_vld;
    logic         load_rdy;
    logic [W-1:0] load_val;
    logic         en;
    logic         abort;
    logic [W-1:0] cnt;
    logic         busy;
    logic         expire;

    modport master (
        output load_vld,
        output load_val,
        output en,
        output abort,
        input  load_rdy,
        input  cnt,
        input  busy,
        input  expire
    );

    modport slave (
        input  load_vld,
        input  load_val,
        input  en,
        input  abort,
        output load_rdy,
        output cnt,
        output busy,
        output expire
    );
endinterface

// File: rtl/decr_timer.sv
// decr_timer: loadable down-counter/timer on a group-borrow-lookahead decrementor.
// Latency: one register stage; a load of N with en held high expires N cycles after the load edge.
// Backpressure: load_rdy is low only in RUN; loads offered then are dropped, not queued.
//
// Ports:
//   clk    : clock, all state on its rising edge
//   rst_n  : synchronous active-low reset
//   tif    : decr_timer_if.slave (load_vld/load_rdy/load_val, en, abort, cnt, busy, expire)
// Parameters:
//   W      : counter width (2..32)
//   GRP    : borrow-lookahead group size; the top group may be partial
// Optional feature macro: DECR_TIMER_RELOAD_EN
//   When defined, every accepted load value is kept in a reload register and a RUN
//   expiry reloads the count instead of stopping, giving a periodic expire tick.
module decr_timer #(
    parameter int W   = 16,
    parameter int GRP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    decr_timer_if.slave tif
);

    localparam int NGRP = (W + GRP - 1) / GRP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q;
    logic [W-1:0] cnt_q;
    logic         busy_q;
    logic         rdy_q;
    logic         expire_q;
`ifdef DECR_TIMER_RELOAD_EN
    logic [W-1:0] reload_q;
`endif

    // ------------------------------------------------------------------
    // Fast decrementor: cnt_d = cnt_q - 1.
    // A group receives a borrow when every lower group is all-zero; the
    // borrow-in is the AND of those flags, not a bit-serial ripple. Inside
    // a group, bit i flips when the borrow reaches the group and bits below
    // it in the same group are all zero.
    // ------------------------------------------------------------------
    logic [W-1:0]    cnt_d;
    logic [NGRP-1:0] grp_zero;
    logic [NGRP-1:0] grp_bin;
    logic            cnt_zero;
    logic            cnt_one;

    genvar g, j;
    generate
        for (g = 0; g < NGRP; g++) begin : g_grp
            localparam int LO = g * GRP;
            localparam int HI = ((g + 1) * GRP > W) ? (W - 1) : ((g + 1) * GRP - 1);

            assign grp_zero[g] = ~|cnt_q[HI:LO];

            if (g == 0) begin : g_bin0
                assign grp_bin[g] = 1'b1;
            end else begin : g_binn
                assign grp_bin[g] = &grp_zero[g-1:0];
            end

            for (j = 0; j <= HI - LO; j++) begin : g_bit
                if (j == 0) begin : g_lsb
                    assign cnt_d[LO] = cnt_q[LO] ^ grp_bin[g];
                end else begin : g_up
                    assign cnt_d[LO+j] = cnt_q[LO+j] ^ (grp_bin[g] & ~|cnt_q[LO+j-1:LO]);
                end
            end
        end
    endgenerate

    // All groups zero is the decrementor's borrow-out: the count is zero.
    assign cnt_zero = &grp_zero;
    assign cnt_one  = cnt_q[0] & ~|cnt_q[W-1:1];

    // ------------------------------------------------------------------
    // Control FSM with registered status outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b1;
            expire_q <= 1'b0;
`ifdef DECR_TIMER_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            expire_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    // abort has no meaning outside RUN, so it is not looked at here.
                    if (tif.load_vld) begin
`ifdef DECR_TIMER_RELOAD_EN
                        reload_q <= tif.load_val;
`endif
                        cnt_q <= tif.load_val;
                        if (tif.load_val != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            rdy_q   <= 1'b0;
                        end else begin
                            // Zero-length timer: skip RUN but still expire once.
                            state_q  <= DONE;
                            busy_q   <= 1'b0;
                            rdy_q    <= 1'b1;
                            expire_q <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (tif.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        rdy_q   <= 1'b1;
                    end else if (cnt_zero) begin
                        // Unreachable by construction; leave RUN rather than wrap.
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        rdy_q   <= 1'b1;
                    end else if (tif.en) begin
                        if (cnt_one) begin
                            expire_q <= 1'b1;
`ifdef DECR_TIMER_RELOAD_EN
                            // Periodic mode: restart from the stored value and stay in RUN.
                            cnt_q    <= reload_q;
`else
                            cnt_q    <= '0;
                            state_q  <= DONE;
                            busy_q   <= 1'b0;
                            rdy_q    <= 1'b1;
`endif
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign tif.cnt      = cnt_q;
    assign tif.busy     = busy_q;
    assign tif.load_rdy = rdy_q;
    assign tif.expire   = expire_q;

endmodule

// File: tb/tb_decr_timer.sv
// tb_decr_timer: directed vector table plus a hand-written latency sequence for decr_timer.
// Latency: outputs sampled 1ns after each rising edge; inputs changed on falling edges.
// Backpressure: load_rdy checked on every row; loads during RUN must be dropped.
module tb_decr_timer;
    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decr_timer_if #(.W(W)) tif ();

    decr_timer #(.W(W), .GRP(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tif   (tif)
    );

    typedef struct {
        logic         rst_n;
        logic         load_vld;
        logic [W-1:0] load_val;
        logic         en;
        logic         abort;
        logic [W-1:0] cnt;
        logic         busy;
        logic         expire;
        logic         rdy;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input logic r, input logic lv, input logic [W-1:0] val,
                       input logic e, input logic ab,
                       input logic [W-1:0] c, input logic b, input logic ex, input logic rd);
        vec_t v;
        v.rst_n = r;  v.load_vld = lv; v.load_val = val; v.en = e; v.abort = ab;
        v.cnt = c;    v.busy = b;      v.expire = ex;    v.rdy = rd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic lv, input logic [W-1:0] val,
                         input logic e, input logic ab);
        @(negedge clk);
        rst_n        = r;
        tif.load_vld = lv;
        tif.load_val = val;
        tif.en       = e;
        tif.abort    = ab;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        tif.load_vld = 1'b0;
        tif.load_val = '0;
        tif.en       = 1'b0;
        tif.abort    = 1'b0;

        //   rst lv  val       en ab  cnt       busy exp rdy
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1);   // reset
        add(0, 1, 16'h1234, 1, 0, 16'h0000, 0, 0, 1);   // reset beats load
        add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1);   // idle
`ifdef DECR_TIMER_RELOAD_EN
        // Periodic tick: 3,2,1,3,2,1 with expire on each reload
        add(1, 1, 16'd3,    1, 0, 16'd3,    1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'd2,    1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'd1,    1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'd3,    1, 1, 0);
        add(1, 0, 16'd0,    1, 0, 16'd2,    1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'd1,    1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'd3,    1, 1, 0);
        add(1, 0, 16'd0,    0, 0, 16'd3,    1, 0, 0);   // en low holds
        add(0, 0, 16'd0,    1, 0, 16'd0,    0, 0, 1);   // reset mid-run
        add(1, 1, 16'd0,    0, 0, 16'd0,    0, 1, 1);   // zero load -> DONE + expire
        add(1, 0, 16'd0,    0, 0, 16'd0,    0, 0, 1);
        add(1, 1, 16'h0100, 0, 0, 16'h0100, 1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'h00FF, 1, 0, 0);   // group borrow
        add(1, 0, 16'd0,    1, 1, 16'h00FF, 0, 0, 1);   // abort exits RUN
`else
        // Basic run of 5
        add(1, 1, 16'd5,    1, 0, 16'd5,    1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'd4,    1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'd3,    1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'd2,    1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'd1,    1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'd0,    0, 1, 1);
        add(1, 0, 16'd0,    1, 0, 16'd0,    0, 0, 1);   // DONE, pulse gone
        // Borrow across groups
        add(1, 1, 16'h0100, 0, 0, 16'h0100, 1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'h00FF, 1, 0, 0);
        add(1, 0, 16'd0,    0, 1, 16'h00FF, 0, 0, 1);
        add(1, 1, 16'h8000, 0, 0, 16'h8000, 1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'h7FFF, 1, 0, 0);
        add(1, 0, 16'd0,    0, 1, 16'h7FFF, 0, 0, 1);
        add(1, 1, 16'h0A00, 0, 0, 16'h0A00, 1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'h09FF, 1, 0, 0);
        add(1, 0, 16'd0,    0, 1, 16'h09FF, 0, 0, 1);
        add(1, 1, 16'hFFFF, 0, 0, 16'hFFFF, 1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'hFFFE, 1, 0, 0);
        add(1, 0, 16'd0,    0, 1, 16'hFFFE, 0, 0, 1);
        add(1, 1, 16'h0001, 0, 0, 16'h0001, 1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'h0000, 0, 1, 1);
        // Gated en, load during RUN dropped, abort beats en
        add(1, 1, 16'd10,   0, 0, 16'd10,   1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'd9,    1, 0, 0);
        add(1, 0, 16'd0,    0, 0, 16'd9,    1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'd8,    1, 0, 0);
        add(1, 0, 16'd0,    0, 0, 16'd8,    1, 0, 0);
        add(1, 1, 16'h0033, 1, 0, 16'd7,    1, 0, 0);   // load in RUN ignored
        add(1, 1, 16'h0055, 1, 1, 16'd7,    0, 0, 1);   // abort: IDLE, holds 7
        add(1, 0, 16'd0,    1, 0, 16'd7,    0, 0, 1);   // IDLE holds
        // Zero load, then load on the expire pulse
        add(1, 1, 16'd0,    0, 0, 16'd0,    0, 1, 1);
        add(1, 0, 16'd0,    0, 0, 16'd0,    0, 0, 1);
        add(1, 1, 16'd2,    1, 0, 16'd2,    1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'd1,    1, 0, 0);
        add(1, 0, 16'd0,    1, 0, 16'd0,    0, 1, 1);
        add(1, 1, 16'd3,    0, 0, 16'd3,    1, 0, 0);   // load while expire high
        add(1, 0, 16'd0,    0, 1, 16'd3,    0, 0, 1);   // abort to IDLE
        add(1, 1, 16'd4,    1, 1, 16'd4,    1, 0, 0);   // abort ignored in IDLE
        add(1, 0, 16'd0,    1, 0, 16'd3,    1, 0, 0);
        add(0, 0, 16'd0,    1, 0, 16'd0,    0, 0, 1);   // reset mid-run
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].load_vld, vecs[i].load_val, vecs[i].en, vecs[i].abort);
            chk("cnt",      i, 32'(tif.cnt),      32'(vecs[i].cnt));
            chk("busy",     i, 32'(tif.busy),     32'(vecs[i].busy));
            chk("expire",   i, 32'(tif.expire),   32'(vecs[i].expire));
            chk("load_rdy", i, 32'(tif.load_rdy), 32'(vecs[i].rdy));
        end

        // Latency: load 7 with en held high; expire must appear 7 edges after the load edge.
        drive(1, 0, 16'd0, 0, 0);
        drive(1, 1, 16'd7, 1, 0);
        k = 0;
        do begin
            drive(1, 0, 16'd0, 1, 0);
            k++;
        end while (!tif.expire && k < 20);
        chk("lat_cycles", 100, 32'(k), 32'd7);
        chk("lat_expire", 100, 32'(tif.expire), 32'd1);
`ifdef DECR_TIMER_RELOAD_EN
        chk("lat_cnt",  100, 32'(tif.cnt),  32'd7);
        chk("lat_busy", 100, 32'(tif.busy), 32'd1);
`else
        chk("lat_cnt",  100, 32'(tif.cnt),  32'd0);
        chk("lat_busy", 100, 32'(tif.busy), 32'd0);
`endif
        drive(1, 0, 16'd0, 1, 0);
        chk("pulse_width", 101, 32'(tif.expire), 32'd0);
        drive(1, 0, 16'd0, 0, 1);
        chk("final_busy", 102, 32'(tif.busy), 32'd0);
        chk("final_rdy",  102, 32'(tif.load_rdy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
